// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the ALU command sequencer: widths, opcodes,
// FSM state encoding and the latched command record.
package alu_seq_pkg;

    localparam int DW = 16;  // datapath width
    localparam int RW = 2;   // register address width

    typedef enum logic [2:0] {
        OP_ADDC  = 3'b000,  // M + N + C
        OP_ADDHN = 3'b001,  // M + (N >>> 1)
        OP_INC   = 3'b010,  // M + 1
        OP_ADDHM = 3'b011,  // M + (M >>> 1)
        OP_AND   = 3'b100,
        OP_OR    = 3'b101,
        OP_NOT   = 3'b110,
        OP_ZERO  = 3'b111
    } opc_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_e;

    // Command fields held stable for every iteration of one command.
    typedef struct packed {
        opc_e          opc;
        logic [RW-1:0] dst;
        logic [RW-1:0] src_m;
        logic [RW-1:0] src_n;
        logic          cin;
    } cmd_t;

endpackage

// File: rtl/alu_seq_ctrl_alu.sv
// Team 16-bit combinational ALU. Signed arithmetic, results wrap mod 2^16.
module myALU_1
    import alu_seq_pkg::*;
(
    input  logic [DW-1:0] m_i,
    input  logic [DW-1:0] n_i,
    input  logic          c_i,
    input  logic [2:0]    opc_i,
    output logic [DW-1:0] out_o,
    output logic          zer_o,
    output logic          neg_o
);

    logic signed [DW-1:0] m_half;
    logic signed [DW-1:0] n_half;

    // Operation select; halves are formed in their own signed variables so
    // the arithmetic shift is not turned logical by an unsigned sum context.
    always_comb begin
        m_half = $signed(m_i) >>> 1;
        n_half = $signed(n_i) >>> 1;
        out_o  = '0;
        case (opc_e'(opc_i))
            OP_ADDC:  out_o = m_i + n_i + {{(DW-1){1'b0}}, c_i};
            OP_ADDHN: out_o = m_i + n_half;
            OP_INC:   out_o = m_i + {{(DW-1){1'b0}}, 1'b1};
            OP_ADDHM: out_o = m_i + m_half;
            OP_AND:   out_o = m_i & n_i;
            OP_OR:    out_o = m_i | n_i;
            OP_NOT:   out_o = ~m_i;
            OP_ZERO:  out_o = '0;
            default:  out_o = '0;
        endcase
        zer_o = (out_o == '0);
        neg_o = out_o[DW-1];
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer around myALU_1: owns the register file, accepts one
// command in IDLE, repeats it (rep + 1) times in EXEC writing back each
// result, then pulses done for one cycle in DONE.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int REPW = 4,
    parameter int NREG = 4
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            cmdValid,
    output logic            cmdReady,
    input  logic [2:0]      cmdOpc,
    input  logic [RW-1:0]   cmdDst,
    input  logic [RW-1:0]   cmdSrcM,
    input  logic [RW-1:0]   cmdSrcN,
    input  logic            cmdCin,
    input  logic [REPW-1:0] cmdRep,
    input  logic            wrEn,
    input  logic [RW-1:0]   wrAddr,
    input  logic [DW-1:0]   wrData,
    input  logic [RW-1:0]   rdAddr,
    output logic [DW-1:0]   rdData,
    output logic            busy,
    output logic            done,
    output logic [DW-1:0]   result,
    output logic            zerF,
    output logic            negF
);

    state_e            state_q, state_d;
    cmd_t              cmd_q;
    logic [REPW-1:0]   cnt_q;
    logic [DW-1:0]     regs_q [NREG];
    logic [DW-1:0]     result_q;
    logic              zer_q, neg_q;

    logic              accept;
    logic              write_back;
    logic              host_we;
    logic [DW-1:0]     alu_out;
    logic              alu_zer, alu_neg;

    myALU_1 u_alu (
        .m_i   (regs_q[cmd_q.src_m]),
        .n_i   (regs_q[cmd_q.src_n]),
        .c_i   (cmd_q.cin),
        .opc_i (cmd_q.opc),
        .out_o (alu_out),
        .zer_o (alu_zer),
        .neg_o (alu_neg)
    );

    // FSM state register.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and handshake/status outputs.
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        cmdReady   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        write_back = 1'b0;
        case (state_q)
            IDLE: begin
                cmdReady = 1'b1;
                if (cmdValid) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                busy       = 1'b1;
                write_back = 1'b1;
                if (cnt_q == '0) state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign host_we = wrEn && (state_q == IDLE);

    // Command latch on acceptance; remaining-iteration counter stops at 0.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cmd_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            cmd_q <= '{opc: opc_e'(cmdOpc), dst: cmdDst, src_m: cmdSrcM,
                       src_n: cmdSrcN, cin: cmdCin};
            cnt_q <= cmdRep;
        end else if (write_back && cnt_q != '0) begin
            cnt_q <= cnt_q - {{(REPW-1){1'b0}}, 1'b1};
        end
    end

    // Register file: ALU write-back in EXEC, host write in IDLE.
    // NOTE: this array is reset on purpose: the host may read any register
    // right after reset and expects zeros, so it cannot map to an unreset RAM.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (write_back) begin
            regs_q[cmd_q.dst] <= alu_out;
        end else if (host_we) begin
            regs_q[wrAddr] <= wrData;
        end
    end

    // Last result and its flags, captured with every write-back.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            result_q <= '0;
            zer_q    <= 1'b0;
            neg_q    <= 1'b0;
        end else if (write_back) begin
            result_q <= alu_out;
            zer_q    <= alu_zer;
            neg_q    <= alu_neg;
        end
    end

    assign rdData = regs_q[rdAddr];
    assign result = result_q;
    assign zerF   = zer_q;
    assign negF   = neg_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: a transaction-level model tracks the
// register file, last result/flags and the iterations still owed; a compare
// process checks every output on each falling edge, and directed scenarios
// pin the model with hand-computed literals.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        cmdValid = 1'b0;
    logic        cmdReady;
    logic [2:0]  cmdOpc = '0;
    logic [1:0]  cmdDst = '0, cmdSrcM = '0, cmdSrcN = '0;
    logic        cmdCin = 1'b0;
    logic [3:0]  cmdRep = '0;
    logic        wrEn = 1'b0;
    logic [1:0]  wrAddr = '0;
    logic [15:0] wrData = '0;
    logic [1:0]  rdAddr = '0;
    logic [15:0] rdData;
    logic        busy, done;
    logic [15:0] result;
    logic        zerF, negF;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.REPW(4), .NREG(4)) dut (
        .clk(clk), .rstN(rstN),
        .cmdValid(cmdValid), .cmdReady(cmdReady),
        .cmdOpc(cmdOpc), .cmdDst(cmdDst), .cmdSrcM(cmdSrcM), .cmdSrcN(cmdSrcN),
        .cmdCin(cmdCin), .cmdRep(cmdRep),
        .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
        .rdAddr(rdAddr), .rdData(rdData),
        .busy(busy), .done(done), .result(result), .zerF(zerF), .negF(negF)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] m,
                                            input logic [15:0] n, input logic c);
        int sm, sn;
        sm = $signed(m);
        sn = $signed(n);
        case (op)
            3'd0:    return 16'(sm + sn + int'(c));
            3'd1:    return 16'(sm + (sn >>> 1));
            3'd2:    return 16'(sm + 1);
            3'd3:    return 16'(sm + (sm >>> 1));
            3'd4:    return m & n;
            3'd5:    return m | n;
            3'd6:    return ~m;
            default: return 16'h0000;
        endcase
    endfunction

    logic [15:0] m_regs [4];
    logic [15:0] m_res = '0;
    bit          m_z = 1'b0, m_n = 1'b0;
    int          m_left = 0;     // write-backs still owed by current command
    bit          m_done = 1'b0;  // done expected this cycle
    logic [2:0]  m_opc = '0;
    logic [1:0]  m_dst = '0, m_sm = '0, m_sn = '0;
    logic        m_cin = 1'b0;
    logic [15:0] m_tmp;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < 4; i++) m_regs[i] = '0;
            m_res = '0; m_z = 1'b0; m_n = 1'b0; m_left = 0; m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            m_tmp = ref_alu(m_opc, m_regs[m_sm], m_regs[m_sn], m_cin);
            m_regs[m_dst] = m_tmp;
            m_res = m_tmp;
            m_z = (m_tmp == 16'h0);
            m_n = m_tmp[15];
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else begin
            if (wrEn) m_regs[wrAddr] = wrData;
            if (cmdValid) begin
                m_opc = cmdOpc; m_dst = cmdDst; m_sm = cmdSrcM; m_sn = cmdSrcN;
                m_cin = cmdCin;
                m_left = int'(cmdRep) + 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en && rstN) begin
            check("cmdReady", cmdReady, (!m_done && m_left == 0));
            check("busy",     busy,     (m_done || m_left > 0));
            check("done",     done,     m_done);
            check("result",   result,   m_res);
            check("zerF",     zerF,     m_z);
            check("negF",     negF,     m_n);
            check("rdData",   rdData,   m_regs[rdAddr]);
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [1:0] a, input logic [15:0] d);
        wrAddr = a; wrData = d; wrEn = 1'b1;
        tick();
        wrEn = 1'b0;
    endtask

    // Holds cmdValid until accepted; any wrEn set by the caller is cleared
    // after the acceptance edge. Returns at acceptance edge + 1.
    task automatic issue(input logic [2:0] opc, input logic [1:0] dst, input logic [1:0] sm,
                         input logic [1:0] sn, input logic cin, input logic [3:0] rep);
        int budget = 0;
        cmdOpc = opc; cmdDst = dst; cmdSrcM = sm; cmdSrcN = sn; cmdCin = cin; cmdRep = rep;
        cmdValid = 1'b1;
        while (!cmdReady && budget < 50) begin
            tick();
            budget++;
        end
        if (!cmdReady) check("accept_timeout", cmdReady, 1);
        tick();
        cmdValid = 1'b0;
        wrEn = 1'b0;
    endtask

    // cyc = index of the cycle (1 = first after acceptance) in which done is seen.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
        if (!done) check("done_timeout", done, 1);
        tick();
    endtask

    task automatic read_chk(input string name, input logic [1:0] a, input logic [15:0] exp);
        rdAddr = a;
        #1;
        check(name, rdData, exp);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int nw;
        // Reset state
        repeat (2) tick();
        check("rst_ready", cmdReady, 1);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_result", result, 16'h0);
        read_chk("rst_r2", 2'd2, 16'h0);
        @(posedge clk); #1 rstN = 1'b1;
        chk_en = 1'b1;
        tick();

        // Reset in the middle of EXEC
        host_write(2'd0, 16'h0005);
        host_write(2'd1, 16'h0007);
        issue(3'b000, 2'd2, 2'd0, 2'd1, 1'b0, 4'd5);
        tick(); tick();
        #1 rstN = 1'b0;
        #1;
        check("abort_ready", cmdReady, 1);
        check("abort_busy",  busy, 0);
        check("abort_done",  done, 0);
        for (int i = 0; i < 4; i++) read_chk("abort_reg", 2'(i), 16'h0);
        @(posedge clk); #1 rstN = 1'b1;
        tick();

        // Add with carry
        host_write(2'd0, 16'h0003);
        host_write(2'd1, 16'h0005);
        issue(3'b000, 2'd2, 2'd0, 2'd1, 1'b1, 4'd0);
        wait_done(cyc);
        check("addc_lat", cyc, 2);
        check("addc_res", result, 16'h0009);
        check("addc_z", zerF, 0);
        check("addc_n", negF, 0);
        read_chk("addc_r2", 2'd2, 16'h0009);

        // Increment chain, rep = 3
        host_write(2'd0, 16'h0001);
        issue(3'b010, 2'd0, 2'd0, 2'd0, 1'b0, 4'd3);
        wait_done(cyc);
        check("inc4_lat", cyc, 5);
        read_chk("inc4_r0", 2'd0, 16'h0005);

        // Signed wrap
        host_write(2'd0, 16'h7FFF);
        issue(3'b010, 2'd1, 2'd0, 2'd0, 1'b0, 4'd0);
        wait_done(cyc);
        read_chk("wrap_r1", 2'd1, 16'h8000);
        check("wrap_n", negF, 1);

        // NOT then ZERO
        host_write(2'd0, 16'h00FF);
        issue(3'b110, 2'd3, 2'd0, 2'd0, 1'b0, 4'd0);
        wait_done(cyc);
        read_chk("not_r3", 2'd3, 16'hFF00);
        check("not_n", negF, 1);
        issue(3'b111, 2'd3, 2'd0, 2'd0, 1'b0, 4'd0);
        wait_done(cyc);
        read_chk("zero_r3", 2'd3, 16'h0000);
        check("zero_z", zerF, 1);

        // Host write while busy is dropped
        issue(3'b010, 2'd2, 2'd1, 2'd0, 1'b0, 4'd2);
        wrAddr = 2'd0; wrData = 16'h1234; wrEn = 1'b1;
        tick(); tick();
        wrEn = 1'b0;
        wait_done(cyc);
        read_chk("busy_wr_r0", 2'd0, 16'h00FF);

        // Host write lands in the acceptance cycle
        wrAddr = 2'd0; wrData = 16'h0010; wrEn = 1'b1;
        issue(3'b011, 2'd1, 2'd0, 2'd0, 1'b0, 4'd0);
        wait_done(cyc);
        read_chk("same_cyc_r1", 2'd1, 16'h0018);

        // Maximum repeat count: 16 iterations, no wrap of the counter
        host_write(2'd0, 16'h0000);
        issue(3'b010, 2'd0, 2'd0, 2'd0, 1'b0, 4'd15);
        wait_done(cyc);
        check("rep15_lat", cyc, 17);
        read_chk("rep15_r0", 2'd0, 16'h0010);

        // Randomised traffic against the model
        for (int t = 0; t < 80; t++) begin
            nw = $urandom_range(0, 2);
            for (int w = 0; w < nw; w++) host_write(2'($urandom), 16'($urandom));
            rdAddr = 2'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                wrAddr = 2'($urandom); wrData = 16'($urandom); wrEn = 1'b1;
            end
            issue(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                  ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) begin
                wrAddr = 2'($urandom); wrData = 16'($urandom); wrEn = 1'b1;
                tick();
                wrEn = 1'b0;
            end
            rdAddr = 2'($urandom);
            wait_done(cyc);
            if ($urandom_range(0, 1) == 0) tick();
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
